dmem_responder: RTL and testbench

- Slave-side data-memory responder for the single-cycle RISC-V core. It is the other end of the MemRead/MemWrite interface driven by the main decoder.
- Accepts one load or store request at a time and models a multi-cycle memory with a fixed, parameterised latency.
- Stalls the core via `stall` until the access completes.
- Sits between the core's datapath and the data-memory array; the array is internal to this block.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and the
// responder (slave). The core drives one request at a time; the responder
// answers with registered rdata/ready/err and a combinational stall.
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              stall;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, err, stall
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Slave-side data memory with a fixed access latency. One word-aligned load
// or store is accepted at a time; the core is held by `stall` until the
// single-cycle `ready` pulse. Simultaneous read+write is rejected with `err`,
// and word indices beyond DEPTH complete normally but flag `err`.
// LATENCY must lie in 1..15 and DEPTH must be a power of two.
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         IW       = ADDR_W - 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [IW-1:0]     lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     req_idx;
  logic              req_valid;
  logic              req_both;
  logic              req_none;
  logic [IW-1:0]     resp_idx;
  logic              resp_in_range;
  logic [DATA_W-1:0] resp_word;
  logic              lat_in_range;

  assign req_idx   = bus.addr[ADDR_W-1:2];
  assign req_valid = bus.mem_read ^ bus.mem_write;
  assign req_both  = bus.mem_read & bus.mem_write;
  assign req_none  = ~(bus.mem_read | bus.mem_write);

  // The core is frozen whenever it requests and the answer is not yet here.
  assign bus.stall = (bus.mem_read | bus.mem_write) & ~bus.ready;

  assign lat_in_range = (lat_idx < IW'(DEPTH));

  // Word addressed by the response being produced: straight from the bus when
  // a LATENCY==1 access completes from IDLE, otherwise the latched index.
  // The range check uses the full index before truncation so nothing aliases.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    resp_idx      = (state == IDLE) ? req_idx : lat_idx;
    resp_in_range = (resp_idx < IW'(DEPTH));
    resp_word     = resp_in_range ? mem[resp_idx[AW-1:0]] : '0;
  end

  // Request sequencing, latency counting and registered response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      bus.rdata <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_both) begin
            bus.err <= 1'b1;
          end else if (req_valid) begin
            lat_write <= bus.mem_write;
            lat_idx   <= req_idx;
            lat_wdata <= bus.wdata;
            cnt       <= CNT_INIT;
            if (LATENCY == 1) begin
              state     <= DONE;
              bus.ready <= 1'b1;
              bus.err   <= ~resp_in_range;
              if (bus.mem_read) bus.rdata <= resp_word;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (req_none) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state     <= DONE;
            bus.ready <= 1'b1;
            bus.err   <= ~resp_in_range;
            if (!lat_write) bus.rdata <= resp_word;
          end
          cnt <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit at the edge that ends the DONE cycle; reset discards it.
  // NOTE: the array is deliberately not reset; only the control path is.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && lat_write && lat_in_range)
      mem[lat_idx[AW-1:0]] <= lat_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=4 and one with
// LATENCY=1, driven one at a time. A transaction-level model (word array plus
// expected response timing) predicts ready/err/stall/rdata every cycle.
module tb_dmem_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mr, mw;
  logic [31:0] ad, wd;
  int          sel;

  dmem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus4 ();
  dmem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  dmem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(4))
    u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  dmem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus4.mem_read  = (sel == 0) ? mr : 1'b0;
  assign bus4.mem_write = (sel == 0) ? mw : 1'b0;
  assign bus4.addr      = ad;
  assign bus4.wdata     = wd;
  assign bus1.mem_read  = (sel == 1) ? mr : 1'b0;
  assign bus1.mem_write = (sel == 1) ? mw : 1'b0;
  assign bus1.addr      = ad;
  assign bus1.wdata     = wd;

  logic        o_ready, o_err, o_stall;
  logic [31:0] o_rdata;
  always_comb begin
    o_ready = (sel == 1) ? bus1.ready : bus4.ready;
    o_err   = (sel == 1) ? bus1.err   : bus4.err;
    o_stall = (sel == 1) ? bus1.stall : bus4.stall;
    o_rdata = (sel == 1) ? bus1.rdata : bus4.rdata;
  end

  // Reference model: one word array per instance plus the expected rdata.
  logic [31:0] mmem   [2][DEPTH];
  bit          mknown [2][DEPTH];
  logic [31:0] exp_rdata [2];
  bit          rdata_known [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat();
    return (sel == 1) ? 1 : 4;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mr = r; mw = w; ad = a; wd = d;
  endtask

  task automatic expect_cycle(input string pfx, input logic rdy, input logic er, input logic stl);
    check({pfx, "_ready"}, o_ready, rdy);
    check({pfx, "_err"},   o_err,   er);
    check({pfx, "_stall"}, o_stall, stl);
    if (rdata_known[sel]) check({pfx, "_rdata"}, o_rdata, exp_rdata[sel]);
  endtask

  task automatic idle(input int n, input string pfx);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, $urandom, $urandom);
      @(negedge clk);
      expect_cycle(pfx, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One load/store. abort_at>0 drops the request in that cycle (must be a
  // BUSY cycle); scramble changes addr/wdata after acceptance.
  task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        input int abort_at, input bit scramble, input string pfx);
    int          n_lat;
    logic [29:0] idx;
    bit          oob;
    bit          aborted;
    n_lat   = lat();
    idx     = a[31:2];
    oob     = (idx >= 30'(DEPTH));
    aborted = 1'b0;
    for (int c = 0; c <= n_lat; c++) begin
      if (abort_at > 0 && c >= abort_at) begin
        drive(1'b0, 1'b0, $urandom, $urandom);
        aborted = 1'b1;
      end else if (c > 0 && scramble) begin
        drive(!is_wr, is_wr, $urandom, $urandom);
      end else begin
        drive(!is_wr, is_wr, a, d);
      end
      @(negedge clk);
      if (aborted) begin
        expect_cycle({pfx, "_abort"}, 1'b0, 1'b0, 1'b0);
      end else if (c < n_lat) begin
        expect_cycle({pfx, "_wait"}, 1'b0, 1'b0, 1'b1);
      end else begin
        if (!is_wr) begin
          if (oob) begin
            exp_rdata[sel]   = '0;
            rdata_known[sel] = 1'b1;
          end else begin
            exp_rdata[sel]   = mmem[sel][idx[AW-1:0]];
            rdata_known[sel] = mknown[sel][idx[AW-1:0]];
          end
        end
        expect_cycle({pfx, "_done"}, 1'b1, oob, 1'b0);
      end
    end
    if (is_wr && !aborted && !oob) begin
      mmem[sel][idx[AW-1:0]]   = d;
      mknown[sel][idx[AW-1:0]] = 1'b1;
    end
  endtask

  // Both requests held for n cycles: err every cycle after the first, then
  // one trailing err pulse after release, never ready.
  task automatic illegal(input int n, input string pfx);
    for (int c = 0; c < n; c++) begin
      drive(1'b1, 1'b1, $urandom & 32'h3C, $urandom);
      @(negedge clk);
      expect_cycle(pfx, 1'b0, (c > 0), 1'b1);
    end
    drive(1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    expect_cycle({pfx, "_tail"}, 1'b0, 1'b1, 1'b0);
    idle(1, {pfx, "_after"});
  endtask

  // Store interrupted by reset in cycle rst_at (0 = acceptance cycle).
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] d, input int rst_at,
                           input string pfx);
    for (int c = 0; c <= rst_at; c++) begin
      drive(1'b0, 1'b1, a, d);
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (c < rst_at) expect_cycle({pfx, "_pre"}, 1'b0, 1'b0, 1'b1);
    end
    exp_rdata[0]   = '0;
    exp_rdata[1]   = '0;
    rdata_known[0] = 1'b1;
    rdata_known[1] = 1'b1;
    drive(1'b0, 1'b0, $urandom, $urandom);
    rst = 1'b0;
    @(negedge clk);
    expect_cycle({pfx, "_post"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_ops(input int n);
    int          r;
    bit          is_wr;
    logic [31:0] a;
    int          abort_at;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        illegal($urandom_range(1, 3), "rnd_ill");
      end else begin
        is_wr = 1'($urandom_range(0, 1));
        if (r < 16)      a = $urandom | 32'h400;
        else if (r < 30) a = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
        else             a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        abort_at = 0;
        if (lat() > 1 && $urandom_range(0, 4) == 0) abort_at = $urandom_range(1, lat() - 1);
        access(is_wr, a, $urandom, abort_at, 1'($urandom_range(0, 1)), "rnd");
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), "rnd_gap");
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel = 0;
    rst = 1'b1;
    mr = 1'b0; mw = 1'b0; ad = '0; wd = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rdata_known[0] = 1'b1; rdata_known[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready4", bus4.ready, 1'b0);
    check("rst_err4",   bus4.err,   1'b0);
    check("rst_rdata4", bus4.rdata, 32'h0);
    check("rst_stall4", bus4.stall, 1'b0);
    check("rst_ready1", bus1.ready, 1'b0);
    check("rst_err1",   bus1.err,   1'b0);
    check("rst_rdata1", bus1.rdata, 32'h0);
    check("rst_stall1", bus1.stall, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // LATENCY=4 directed
    sel = 0;
    access(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, "st10");
    idle(1, "gap");
    access(1'b1, 32'h00, 32'h11112222, 0, 1'b0, "st00");
    idle(1, "gap");
    access(1'b0, 32'h10, '0, 0, 1'b0, "ld10");
    idle(1, "gap");
    access(1'b0, 32'h13, '0, 0, 1'b0, "ld13");
    access(1'b1, 32'h14, 32'h01234567, 0, 1'b1, "b2b_st14");
    access(1'b0, 32'h14, '0, 0, 1'b0, "b2b_ld14");
    idle(1, "gap");
    access(1'b0, 32'h400, '0, 0, 1'b0, "oob_ld");
    access(1'b0, 32'h00, '0, 0, 1'b0, "ld00_alias");
    access(1'b1, 32'h404, 32'hBAD0BAD0, 0, 1'b0, "oob_st");
    access(1'b0, 32'h04, '0, 0, 1'b0, "ld04_unknown");
    idle(1, "gap");
    illegal(1, "ill1");
    access(1'b0, 32'h10, '0, 0, 1'b0, "ld10_after_ill");
    idle(1, "gap");
    illegal(3, "ill3");
    access(1'b1, 32'h20, 32'hA5A5A5A5, 0, 1'b0, "st20");
    idle(1, "gap");
    access(1'b1, 32'h20, 32'h5A5A5A5A, 2, 1'b0, "st20_abort");
    access(1'b0, 32'h20, '0, 0, 1'b0, "ld20");
    access(1'b1, 32'h20, 32'h77777777, 3, 1'b0, "st20_abort_late");
    access(1'b0, 32'h20, '0, 0, 1'b0, "ld20_b");
    idle(1, "gap");
    reset_mid(32'h10, 32'hCAFEF00D, 2, "rst_busy");
    access(1'b0, 32'h10, '0, 0, 1'b0, "ld10_after_rst");
    idle(1, "gap");
    reset_mid(32'h10, 32'hCAFEF00D, 4, "rst_done");
    access(1'b0, 32'h10, '0, 0, 1'b0, "ld10_after_rst_done");
    idle(1, "gap");
    rand_ops(80);
    idle(2, "switch");

    // LATENCY=1 directed
    sel = 1;
    access(1'b1, 32'h10, 32'h600DF00D, 0, 1'b0, "l1_st10");
    access(1'b0, 32'h10, '0, 0, 1'b0, "l1_ld10");
    access(1'b0, 32'h400, '0, 0, 1'b0, "l1_oob");
    illegal(2, "l1_ill");
    access(1'b0, 32'h12, '0, 0, 1'b0, "l1_ld12");
    reset_mid(32'h10, 32'h0BADC0DE, 0, "l1_rst_acc");
    access(1'b0, 32'h10, '0, 0, 1'b0, "l1_ld_after_rst");
    reset_mid(32'h10, 32'h0BADC0DE, 1, "l1_rst_done");
    access(1'b0, 32'h10, '0, 0, 1'b0, "l1_ld_after_rst_done");
    idle(1, "gap");
    rand_ops(80);
    idle(2, "end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
